// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling shuffle over a 256x8 S-memory behind a synchronous single-port RAM.
// Each iteration reads s[i] and s[j], then swaps them with two back-to-back writes.
module ksa_shuffle_fsm #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic                   finish,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_I,
        CAPT_I,
        READ_J,
        CAPT_J,
        WRITE_I,
        WRITE_J,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    i;
    logic [7:0]    j;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [KW-1:0] kidx;
    logic [7:0]    key_byte;

    // key[0] sits in the most significant byte of secret_key
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KW'(k)) begin
                key_byte = secret_key[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            kidx  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        i    <= '0;
                        j    <= '0;
                        kidx <= '0;
                    end
                end
                CAPT_I: begin
                    si <= q;
                    j  <= j + q + key_byte;
                end
                CAPT_J: begin
                    sj <= q;
                end
                WRITE_J: begin
                    i    <= i + 8'd1;
                    kidx <= (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + KW'(1);
                end
                default: ;
            endcase
        end
    end

    // start is only honoured from IDLE or DONE; a pulse mid-run is ignored
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = READ_I;
            READ_I:  next_state = CAPT_I;
            CAPT_I:  next_state = READ_J;
            READ_J:  next_state = CAPT_J;
            CAPT_J:  next_state = WRITE_I;
            WRITE_I: next_state = WRITE_J;
            WRITE_J: next_state = (i == 8'hFF) ? DONE : READ_I;
            DONE:    if (start) next_state = READ_I;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        address = '0;
        data    = '0;
        wren    = 1'b0;
        finish  = 1'b0;
        case (state)
            READ_I, CAPT_I: address = i;
            READ_J, CAPT_J: address = j;
            WRITE_I: begin
                address = i;
                data    = sj;
                wren    = 1'b1;
            end
            WRITE_J: begin
                address = j;
                data    = si;
                wren    = 1'b1;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Bench for ksa_shuffle_fsm: a behavioural RAM, a software KSA model feeding a write
// scoreboard, and directed runs covering reset, handshake, busy start and j wrap.
module tb_ksa_shuffle_fsm;

    localparam int KEY_BYTES = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        finish;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic [7:0] ram   [256];
    logic [7:0] model [256];
    logic       preload_req;
    logic       preload_rev;
    wr_t        exp_q [$];
    wr_t        wlog  [$];
    int         write_count = 0;
    int         tests_run = 0;
    int         tests_failed = 0;
    int         base;

    ksa_shuffle_fsm #(.KEY_BYTES(KEY_BYTES)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .finish     (finish),
        .address    (address),
        .data       (data),
        .wren       (wren)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM; the preload strobe fills it in one edge
    always @(posedge clock) begin
        if (preload_req) begin
            for (int k = 0; k < 256; k++) ram[k] <= preload_rev ? 8'(255 - k) : 8'(k);
        end else if (wren) begin
            ram[address] <= data;
        end
        q <= ram[address];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write cycle is logged and compared against the scoreboard queue
    initial begin
        forever begin
            wr_t got;
            wr_t want;
            @(negedge clock);
            if (!reset && wren === 1'b1) begin
                got = {address, data};
                wlog.push_back(got);
                write_count++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", address, data);
                end else begin
                    want = exp_q.pop_front();
                    checkOutput("write", 32'(got), 32'(want));
                end
            end
        end
    end

    task automatic preloadRam(input logic rev);
        preload_rev = rev;
        preload_req = 1'b1;
        @(posedge clock);
        #1 preload_req = 1'b0;
        for (int k = 0; k < 256; k++) model[k] = rev ? 8'(255 - k) : 8'(k);
    endtask

    // Software KSA over the model memory; each swap pushes its two expected writes
    task automatic modelRun(input logic [23:0] key, input int iters);
        logic [7:0] jm;
        logic [7:0] kb;
        logic [7:0] t;
        jm = 8'd0;
        for (int n = 0; n < iters; n++) begin
            kb = key[8*(2 - (n % 3)) +: 8];
            jm = jm + model[n] + kb;
            exp_q.push_back({8'(n), model[jm]});
            exp_q.push_back({jm, model[n]});
            t         = model[n];
            model[n]  = model[jm];
            model[jm] = t;
        end
    endtask

    task automatic applyStimulus(input logic [23:0] key, input int iters, output int wbase);
        modelRun(key, iters);
        wbase      = write_count;
        secret_key = key;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        checkOutput("finish_low_at_accept", 32'(finish), 32'd0);
    endtask

    task automatic waitFinish(input int busy_at, input int wbase, input string tag);
        int cycles;
        cycles = 0;
        while (cycles < 2000) begin
            @(posedge clock);
            cycles++;
            #1 start = (cycles == busy_at);
            if (finish === 1'b1) break;
        end
        start = 1'b0;
        checkOutput({tag, "_finish_latency"}, 32'(cycles), 32'd1536);
        checkOutput({tag, "_write_cycles"}, 32'(write_count - wbase), 32'd512);
        checkOutput({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkMemory(input string tag);
        int diffs;
        diffs = 0;
        for (int k = 0; k < 256; k++) if (ram[k] !== model[k]) diffs++;
        checkOutput({tag, "_mem_diffs"}, 32'(diffs), 32'd0);
    endtask

    initial begin
        logic seen [256];
        int   distinct;

        reset       = 1'b1;
        start       = 1'b0;
        secret_key  = '0;
        preload_req = 1'b0;
        preload_rev = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_finish", 32'(finish), 32'd0);
        checkOutput("reset_wren", 32'(wren), 32'd0);
        checkOutput("reset_address", 32'(address), 32'd0);
        checkOutput("reset_data", 32'(data), 32'd0);
        reset = 1'b0;

        // Key 0 on identity memory: the first two swaps are self-swaps
        preloadRam(1'b0);
        applyStimulus(24'h000000, 256, base);
        waitFinish(-1, base, "key0");
        checkOutput("key0_w0", 32'(wlog[base + 0]), 32'h0000);
        checkOutput("key0_w1", 32'(wlog[base + 1]), 32'h0000);
        checkOutput("key0_w2", 32'(wlog[base + 2]), 32'h0101);
        checkOutput("key0_w3", 32'(wlog[base + 3]), 32'h0101);
        checkOutput("key0_w4", 32'(wlog[base + 4]), 32'h0203);
        checkOutput("key0_w5", 32'(wlog[base + 5]), 32'h0302);
        repeat (20) @(posedge clock);
        #1 checkOutput("finish_held", 32'(finish), 32'd1);

        // Reset early in iteration 10, then restart from the partially shuffled memory
        preloadRam(1'b0);
        applyStimulus(24'h000000, 10, base);
        for (int c = 0; c < 200 && (write_count - base) < 20; c++) @(negedge clock);
        checkOutput("partial_writes", 32'(write_count - base), 32'd20);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midrun_reset_finish", 32'(finish), 32'd0);
        checkOutput("midrun_reset_wren", 32'(wren), 32'd0);
        checkOutput("midrun_reset_address", 32'(address), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        applyStimulus(24'h000102, 256, base);
        waitFinish(-1, base, "after_reset");
        checkMemory("after_reset");

        preloadRam(1'b0);
        applyStimulus(24'h010000, 256, base);
        waitFinish(-1, base, "key010000");
        checkOutput("key010000_w0", 32'(wlog[base + 0]), 32'h0001);
        checkOutput("key010000_w1", 32'(wlog[base + 1]), 32'h0100);

        // Full run with a stray start pulse at cycle 100
        preloadRam(1'b0);
        applyStimulus(24'h000102, 256, base);
        waitFinish(100, base, "busy_start");
        checkMemory("key000102");
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 256; k++) seen[ram[k]] = 1'b1;
        distinct = 0;
        for (int k = 0; k < 256; k++) if (seen[k]) distinct++;
        checkOutput("permutation", 32'(distinct), 32'd256);

        // Start from DONE reruns on the current memory contents
        applyStimulus(24'h000102, 256, base);
        waitFinish(-1, base, "rerun");
        checkMemory("rerun");

        // Reverse-ordered memory with an all-ones key exercises j wrap-around
        preloadRam(1'b1);
        applyStimulus(24'hFFFFFF, 256, base);
        waitFinish(-1, base, "wrap");
        checkMemory("wrap");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ksa_shuffle_fsm.md
# ksa_shuffle_fsm

Task 2a responder for the RC4 datapath. The controller issues a one-cycle `start` pulse and waits in a wait state until `finish` is high. On `start`, this block runs the RC4 key-scheduling shuffle over the 256×8 S-memory, which Task 1 has already filled with s[i]=i. It then raises `finish` and holds it. It owns the S-memory port for the whole run and drives it with synchronous single-port RAM timing.

## Interface
- KEY_BYTES, 3: key length in bytes. The schedule uses key[i mod KEY_BYTES].
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle start pulse from the controller.
- finish  out  1  high while in DONE; held until the next accepted start.
- secret_key  in  8*KEY_BYTES  key. key[0] = secret_key[23:16], key[1] = [15:8], key[2] = [7:0]. The value is stable while busy.
- address  out  8  S-memory address.
- data  out  8  S-memory write data.
- wren  out  1  S-memory write enable.
- q  in  8  S-memory read data. Valid during the cycle after the cycle in which the address was presented.

## Operation
- Registers:
  - i: 8 bits.
  - j: 8 bits.
  - si, sj: 8 bits each.
  - kidx: key index, 0..KEY_BYTES-1. It tracks i mod KEY_BYTES and avoids a divider.
- States: IDLE, READ_I, CAPT_I, READ_J, CAPT_J, WRITE_I, WRITE_J, DONE. Each state lasts one cycle except IDLE and DONE.
- IDLE: address=0, wren=0, finish=0.
  - start=1 → READ_I, with i=0, j=0, kidx=0.
- READ_I: address=i, wren=0 → CAPT_I.
- CAPT_I: address=i. At the edge, si<=q and j<=j+q+key[kidx], mod 256 (8-bit wrap, carries dropped) → READ_J.
- READ_J: address=j (the updated value), wren=0 → CAPT_J.
- CAPT_J: address=j. At the edge, sj<=q → WRITE_I.
- WRITE_I: address=i, data=sj, wren=1 → WRITE_J.
- WRITE_J: address=j, data=si, wren=1. At the edge:
  - i<=i+1.
  - kidx<=(kidx==KEY_BYTES-1)?0:kidx+1.
  - If i==255 → DONE, else → READ_I.
- DONE: finish=1, wren=0, address=0.
  - start=1 → READ_I, with i=j=kidx=0. finish drops at that same edge.
- i==j: both writes hit the same address with the same value, so the result is a correct no-op swap. This case needs no special handling.
- start while busy (any state other than IDLE or DONE): ignored. The run continues unchanged.
- reset (any state, including mid-run): next state IDLE.
  - i, j, kidx, si, sj cleared.
  - finish=0, wren=0, address=0, data=0.
  - Partially shuffled memory is left as is.

## Timing
- Reset values: finish=0, wren=0, address=0, data=0, state=IDLE.
- Outputs are decoded from the registered state and registers only. There is no combinational path from start or q to any output.
- Each iteration takes exactly 6 cycles. A full run takes 256×6 = 1536 cycles.
- Call E0 the edge that samples start=1. READ_I occupies the cycle after E0. DONE is entered at edge E0+1536, so finish is first high in the cycle after that edge.
- Handshake:
  - finish is low no later than the edge that accepts start, so the controller's wait state never sees a stale finish.
  - finish then stays high indefinitely until the next start or reset.
- Exactly two write cycles per iteration: WRITE_I then WRITE_J. wren is never high in any other state.

## Test plan
- Reset mid-run: assert reset during iteration 10.
  - Next cycle: finish=0, wren=0, address=0.
  - A subsequent start begins at i=0, with j=0 (the first CAPT_I computes j from 0).
- Key 0x000000, RAM preloaded s[i]=i, pulse start:
  - Iterations 0 and 1 write same-address no-ops: addr 0 gets 0, addr 1 gets 1.
  - Iteration 2 writes addr 2 ← 3, then addr 3 ← 2.
  - finish rises exactly 1536 edges after start is sampled.
- Key 0x010000, identity RAM: first writes are addr 0 ← 1, then addr 1 ← 0.
- Key 0x000102, identity RAM, full run:
  - Final 256-byte memory matches a software KSA model.
  - The memory is a permutation of 0..255.
  - wren is high in exactly 512 cycles.
- Restart and busy handling:
  - start pulsed at cycle 100 of a run is ignored, and finish still arrives at E0+1536.
  - start pulsed while in DONE clears finish at the accepting edge and reruns from the current memory contents.
- j wrap-around with key 0xFFFFFF and RAM preset s[i]=255-i: every j update matches the model mod 256, with no carries into state.
